// File: rtl/io_port_pkg.sv
// Shared constants and helpers for the IO port bridge.
// The optional statistics counters are enabled with IO_PORT_STAT_EN.
package io_port_pkg;

    localparam int STATW = 16;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of one output FIFO entry: {channel, data}.
    function automatic int entry_width(input int nboa, input int nubits);
        return nboa + nubits;
    endfunction

    // Saturating event counter. A clear still counts an event seen in the same cycle.
    function automatic logic [STATW-1:0] stat_next(input logic [STATW-1:0] cnt,
                                                   input logic ev, input logic clr);
        if (clr)
            return {{(STATW-1){1'b0}}, ev};
        else if (ev && cnt != {STATW{1'b1}})
            return cnt + STATW'(1);
        else
            return cnt;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with registered storage and an occupancy counter.
// Head data is read straight from storage, so there is no fall-through.
module io_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/io_port_bridge.sv
// IO bus responder: input holding registers for core reads, output FIFO for core writes.
// Define IO_PORT_STAT_EN to add saturating ovf_cnt/udf_cnt event counters.
module io_port_bridge
    import io_port_pkg::*;
#(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 3,
    parameter int NBIA   = clog2_min1(NUIOIN),
    parameter int NBOA   = clog2_min1(NUIOOU)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [NBIA-1:0]   addr_in,
    output logic [NUBITS-1:0] io_in,
    input  logic              out_en,
    input  logic [NBOA-1:0]   addr_out,
    input  logic [NUBITS-1:0] data_out,
    input  logic              ext_wr,
    input  logic [NBIA-1:0]   ext_wr_addr,
    input  logic [NUBITS-1:0] ext_wr_data,
    output logic [NUIOIN-1:0] ch_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NBOA-1:0]   out_addr,
    output logic [NUBITS-1:0] out_data,
    output logic              ovf,
    output logic              udf,
`ifdef IO_PORT_STAT_EN
    output logic [STATW-1:0]  ovf_cnt,
    output logic [STATW-1:0]  udf_cnt,
`endif
    input  logic              clr_flags
);
    localparam int NPAD = 1 << NBIA;
    localparam int EW   = entry_width(NBOA, NUBITS);

    logic [NUBITS-1:0] hold_q [NPAD];
    logic [NPAD-1:0]   valid_q, valid_d, ch_exists;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              rd_miss, wr_ok, drop;
    logic              fifo_full, fifo_empty, pop;
    logic [EW-1:0]     fifo_rdata;

    // Channel addresses past NUIOIN are decodable but have no storage behind them.
    always_comb begin
        ch_exists = '0;
        for (int i = 0; i < NUIOIN; i++) ch_exists[i] = 1'b1;
    end

    assign io_in   = ch_exists[addr_in] ? hold_q[addr_in] : '0;
    assign rd_miss = req_in & ~(ch_exists[addr_in] & valid_q[addr_in]);
    assign wr_ok   = ext_wr & ch_exists[ext_wr_addr];

    // The producer write is applied after the read clear, so it wins on a shared channel.
    always_comb begin
        valid_d = valid_q;
        if (req_in) valid_d[addr_in] = 1'b0;
        if (wr_ok)  valid_d[ext_wr_addr] = 1'b1;
    end

    assign pop   = out_valid & out_ready;
    assign drop  = out_en & fifo_full & ~pop;
    assign ovf_d = drop | (ovf_q & ~clr_flags);
    assign udf_d = rd_miss | (udf_q & ~clr_flags);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPAD; i++) hold_q[i] <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_ok) hold_q[ext_wr_addr] <= ext_wr_data;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    io_sync_fifo #(.W(EW), .AW(FDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (out_en),
        .pop_i   (pop),
        .wdata_i ({addr_out, data_out}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid            = ~fifo_empty;
    assign {out_addr, out_data} = fifo_rdata;
    assign ch_valid             = valid_q[NUIOIN-1:0];
    assign ovf                  = ovf_q;
    assign udf                  = udf_q;

`ifdef IO_PORT_STAT_EN
    logic [STATW-1:0] ovf_cnt_q, udf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= stat_next(ovf_cnt_q, drop, clr_flags);
            udf_cnt_q <= stat_next(udf_cnt_q, rd_miss, clr_flags);
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`endif

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Peripheral-side responder for the processor's IO bus.
- Serves core input reads (req_in/addr_in → io_in) from per-channel holding registers loaded by external producers.
- Captures core output writes (out_en/addr_out/data_out) into an output FIFO that external consumers drain with a valid/ready handshake.
- Sits between the core's IO pins and the system fabric, one instance per core.

Parameters:
- NUBITS, 32, data width (matches core).
- NUIOIN, 8, number of input channels.
- NUIOOU, 8, number of output channels.
- FDEPTH, 3, log2 of output FIFO depth (8 entries).
- NBIA, $clog2(NUIOIN) (min 1), input channel address width (derived).
- NBOA, $clog2(NUIOOU) (min 1), output channel address width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_in  in  1  core input read strobe.
- addr_in  in  NBIA  core input channel select.
- io_in  out  NUBITS  read data to core.
- out_en  in  1  core output write strobe.
- addr_out  in  NBOA  core output channel.
- data_out  in  NUBITS  core output data.
- ext_wr  in  1  producer write strobe.
- ext_wr_addr  in  NBIA  producer channel.
- ext_wr_data  in  NUBITS  producer data.
- ch_valid  out  NUIOIN  per-channel "unread data present".
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_addr  out  NBOA  head channel.
- out_data  out  NUBITS  head data.
- ovf  out  1  sticky: core write dropped on full FIFO.
- udf  out  1  sticky: core read of an empty channel.
- clr_flags  in  1  clears ovf/udf.

Behaviour:
- Clock and reset: clk only; rst is synchronous and active-high. On rst, all holding registers = 0, ch_valid = 0, FIFO empty (out_valid = 0, out_addr = 0, out_data = 0), ovf = 0, udf = 0.
- Input read path:
  - io_in = hold[addr_in], combinational, zero latency. The core samples it in the same cycle it asserts req_in.
  - On posedge with req_in = 1: ch_valid[addr_in] <= 0. If ch_valid[addr_in] was already 0, udf <= 1 and io_in returns the stale held value.
  - addr_in ≥ NUIOIN: io_in = 0, and udf is set on req_in.
- Producer write: on posedge with ext_wr = 1, hold[ext_wr_addr] <= ext_wr_data and ch_valid[ext_wr_addr] <= 1. Overwriting a valid channel is legal and raises no flag (latest value wins).
- Simultaneous ext_wr and req_in on the same channel: the core sees the old data this cycle; the write wins, so after the edge ch_valid = 1 with the new data.
- Output write path:
  - On posedge with out_en = 1 and FIFO not full (or full with a pop in the same cycle): push {addr_out, data_out}.
  - Full and no pop: the entry is dropped and ovf <= 1.
- Output handshake:
  - Transfer when out_valid & out_ready; the head is popped at that edge.
  - out_addr/out_data come directly from FIFO storage and hold stable while out_valid & !out_ready.
  - Latency from push to out_valid = 1 cycle when the FIFO is empty (no fall-through).
- Simultaneous push and pop: allowed at any occupancy. Count is unchanged; pointers wrap modulo 2^FDEPTH.
- addr_out ≥ NUIOOU is stored unchanged; the consumer handles it.
- Flags:
  - clr_flags has priority below a same-cycle set, so a set event in the clearing cycle leaves the flag at 1.
  - rst mid-operation discards FIFO contents and holding data.

Optional Feature:
- Macro IO_PORT_STAT_EN.
- Defined: adds outputs ovf_cnt[15:0] and udf_cnt[15:0]. Each increments on every drop or underflow event, saturates at 16'hFFFF, and is cleared by rst or clr_flags (a clear in the same cycle as an event yields 1).
- Undefined: ports absent; only the sticky flags exist.

Decomposition:
- Package io_port_pkg holds:
  - the localparam function for clog2-with-min-1;
  - the FIFO entry packing width NBOA+NUBITS;
  - the counter width constant STATW = 16.
- One sub-module io_sync_fifo (width, log2 depth) with push/pop/full/empty, registered read storage, and an occupancy counter of FDEPTH+1 bits.

Test Plan:
- Ext write ch3 = 32'hDEADBEEF, then core req_in with addr_in = 3 → io_in = DEADBEEF in that cycle; ch_valid[3] 1 → 0; udf stays 0.
- Second req_in on ch3 with no refill → io_in = DEADBEEF, udf = 1; clr_flags → udf = 0.
- Same-cycle ext_wr ch5 = 0x22 and req_in ch5 with old value 0x11 → io_in = 0x11; next cycle ch_valid[5] = 1, hold = 0x22.
- 8 out_en writes (addr k, data 100+k) with out_ready = 0 → full; 9th write → dropped, ovf = 1. Then out_ready = 1 → drains addr 0..7 with data 100..107 in order.
- Continuous out_en and out_ready = 1 for 20 cycles, starting empty → first out_valid one cycle after the first push; no drop; entries in order; pointers wrap.
- With IO_PORT_STAT_EN: 3 overflow drops → ovf_cnt = 3; rst asserted mid-stream → all outputs return to reset values on the next edge.
